// File: rtl/imem_loadable.sv
// Run-time loadable instruction memory for the LEGv8 fetch stage.
// Self-clears to FILL_WORD after reset, then serves registered fetches and loader writes.
module imem_loadable #(
  parameter int              N         = 32,
  parameter int              DEPTH     = 256,
  parameter int              ADDR_W    = 8,
  parameter logic [N-1:0]    FILL_WORD = 32'h8b1f03ff
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ld_en,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [N-1:0]      ld_data,
  input  logic              fetch_req,
  input  logic [ADDR_W-1:0] addr,
  input  logic              stall,
  output logic              ready,
  output logic [N-1:0]      q,
  output logic              q_valid,
  output logic              addr_err
);

  localparam logic [ADDR_W:0]   DEPTH_X  = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH-1);

  typedef enum logic {S_CLEAR, S_RUN} state_e;

  state_e            state_q;
  logic [ADDR_W-1:0] clr_cnt_q;
  logic              ready_q;
  logic [N-1:0]      q_q;
  logic              q_valid_q;
  logic              addr_err_q;

  logic [N-1:0]      mem [0:DEPTH-1];

  logic              ld_ok;
  logic              fetch_oob;
  logic              bypass;
  logic              we_d;
  logic [ADDR_W-1:0] waddr_d;
  logic [N-1:0]      wdata_d;

  // One shared write port: the clear sequence owns it until RUN, then the loader.
  always_comb begin
    ld_ok     = ld_en && ({1'b0, ld_addr} < DEPTH_X);
    fetch_oob = ({1'b0, addr} >= DEPTH_X);
    bypass    = ld_ok && (ld_addr == addr);
    we_d      = 1'b0;
    waddr_d   = clr_cnt_q;
    wdata_d   = FILL_WORD;
    if (reset) begin
      if (state_q == S_CLEAR) begin
        we_d = 1'b1;
      end else if (ld_ok) begin
        we_d    = 1'b1;
        waddr_d = ld_addr;
        wdata_d = ld_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (we_d) begin
      mem[waddr_d] <= wdata_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= S_CLEAR;
      clr_cnt_q  <= '0;
      ready_q    <= 1'b0;
      q_q        <= FILL_WORD;
      q_valid_q  <= 1'b0;
      addr_err_q <= 1'b0;
    end else begin
      case (state_q)
        S_CLEAR: begin
          clr_cnt_q <= clr_cnt_q + ADDR_W'(1);
          if (clr_cnt_q == LAST_IDX) begin
            state_q <= S_RUN;
            ready_q <= 1'b1;
          end
        end
        S_RUN: begin
          if (!stall) begin
            q_valid_q  <= fetch_req;
            addr_err_q <= fetch_req && fetch_oob;
            // Same-cycle write to the fetched word forwards the new data.
            if (fetch_req) begin
              q_q <= fetch_oob ? FILL_WORD : (bypass ? ld_data : mem[addr]);
            end
          end
        end
      endcase
    end
  end

  assign ready    = ready_q;
  assign q        = q_q;
  assign q_valid  = q_valid_q;
  assign addr_err = addr_err_q;

endmodule

// File: tb/tb_imem_loadable.sv
// Scoreboard bench for imem_loadable: a 256-word instance and a 200-word instance.
module tb_imem_loadable;

  localparam logic [31:0] FILL = 32'h8b1f03ff;

  typedef struct {
    int          cyc;
    logic [31:0] q;
    logic        err;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        ld_en_a, fetch_req_a, stall_a;
  logic [7:0]  ld_addr_a, addr_a;
  logic [31:0] ld_data_a;
  logic        ready_a, q_valid_a, err_a;
  logic [31:0] q_a;

  logic        ld_en_b, fetch_req_b, stall_b;
  logic [7:0]  ld_addr_b, addr_b;
  logic [31:0] ld_data_b;
  logic        ready_b, q_valid_b, err_b;
  logic [31:0] q_b;

  imem_loadable u_a (
    .clk(clk), .reset(rst_n), .ld_en(ld_en_a), .ld_addr(ld_addr_a), .ld_data(ld_data_a),
    .fetch_req(fetch_req_a), .addr(addr_a), .stall(stall_a),
    .ready(ready_a), .q(q_a), .q_valid(q_valid_a), .addr_err(err_a)
  );

  imem_loadable #(.DEPTH(200)) u_b (
    .clk(clk), .reset(rst_n), .ld_en(ld_en_b), .ld_addr(ld_addr_b), .ld_data(ld_data_b),
    .fetch_req(fetch_req_b), .addr(addr_b), .stall(stall_b),
    .ready(ready_b), .q(q_b), .q_valid(q_valid_b), .addr_err(err_b)
  );

  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;
  exp_t sb_a[$];
  exp_t sb_b[$];
  exp_t ea, eb;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end else begin
      $display("check %s = %h ok", name, act);
    end
  endtask

  task automatic fetch_a(input logic [7:0] a, input logic [31:0] eq, input logic ee);
    fetch_req_a = 1'b1; addr_a = a; stall_a = 1'b0;
    sb_a.push_back('{cyc + 1, eq, ee});
  endtask

  task automatic fetch_b(input logic [7:0] a, input logic [31:0] eq, input logic ee);
    fetch_req_b = 1'b1; addr_b = a; stall_b = 1'b0;
    sb_b.push_back('{cyc + 1, eq, ee});
  endtask

  task automatic load_a(input logic [7:0] a, input logic [31:0] d);
    ld_en_a = 1'b1; ld_addr_a = a; ld_data_a = d;
  endtask

  task automatic load_b(input logic [7:0] a, input logic [31:0] d);
    ld_en_b = 1'b1; ld_addr_b = a; ld_data_b = d;
  endtask

  task automatic idle_all();
    ld_en_a = 1'b0; fetch_req_a = 1'b0; stall_a = 1'b0;
    ld_en_b = 1'b0; fetch_req_b = 1'b0; stall_b = 1'b0;
  endtask

  // Monitors: every cycle with q_valid high consumes exactly one expected entry.
  always @(negedge clk) begin
    if (q_valid_a) begin
      n_cmp++;
      if (sb_a.size() == 0) begin
        n_bad++;
        $display("FAIL a_unexpected_valid: got q=%h err=%b at cycle %0d, required no output", q_a, err_a, cyc);
      end else begin
        ea = sb_a.pop_front();
        if (ea.cyc != cyc || q_a !== ea.q || err_a !== ea.err) begin
          n_bad++;
          $display("FAIL a_fetch: got cyc=%0d q=%h err=%b, required cyc=%0d q=%h err=%b",
                   cyc, q_a, err_a, ea.cyc, ea.q, ea.err);
        end else begin
          $display("a fetch cyc=%0d q=%h err=%b ok", cyc, q_a, err_a);
        end
      end
    end else if (sb_a.size() > 0 && sb_a[0].cyc <= cyc) begin
      n_cmp++;
      n_bad++;
      ea = sb_a.pop_front();
      $display("FAIL a_missing_valid: got q_valid=0 at cycle %0d, required q=%h err=%b", cyc, ea.q, ea.err);
    end
  end

  always @(negedge clk) begin
    if (q_valid_b) begin
      n_cmp++;
      if (sb_b.size() == 0) begin
        n_bad++;
        $display("FAIL b_unexpected_valid: got q=%h err=%b at cycle %0d, required no output", q_b, err_b, cyc);
      end else begin
        eb = sb_b.pop_front();
        if (eb.cyc != cyc || q_b !== eb.q || err_b !== eb.err) begin
          n_bad++;
          $display("FAIL b_fetch: got cyc=%0d q=%h err=%b, required cyc=%0d q=%h err=%b",
                   cyc, q_b, err_b, eb.cyc, eb.q, eb.err);
        end else begin
          $display("b fetch cyc=%0d q=%h err=%b ok", cyc, q_b, err_b);
        end
      end
    end else if (sb_b.size() > 0 && sb_b[0].cyc <= cyc) begin
      n_cmp++;
      n_bad++;
      eb = sb_b.pop_front();
      $display("FAIL b_missing_valid: got q_valid=0 at cycle %0d, required q=%h err=%b", cyc, eb.q, eb.err);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, nb;
    rst_n = 1'b0;
    ld_addr_a = '0; addr_a = '0; ld_data_a = '0;
    ld_addr_b = '0; addr_b = '0; ld_data_b = '0;
    idle_all();
    tick(); tick();
    chk("rst_ready", {31'd0, ready_a}, 32'd0);
    chk("rst_q", q_a, FILL);
    chk("rst_q_valid", {31'd0, q_valid_a}, 32'd0);
    chk("rst_addr_err", {31'd0, err_a}, 32'd0);

    // Loader and fetch traffic during the clear must be ignored.
    load_a(8'd3, 32'hdeadbeef);
    fetch_req_a = 1'b1; addr_a = 8'd3;
    rst_n = 1'b1;
    n = 0; nb = 0;
    do begin
      tick(); n++;
      if (ready_b && nb == 0) nb = n;
    end while (!ready_a && n < 400);
    chk("a_clear_cycles", n, 32'd256);
    chk("b_clear_cycles", nb, 32'd200);
    idle_all();

    fetch_a(8'h10, FILL, 1'b0); tick();
    fetch_a(8'h03, FILL, 1'b0); tick();
    idle_all(); tick();

    load_a(8'h00, 32'hf8000001); tick();
    load_a(8'h01, 32'hf8008002); tick();
    ld_en_a = 1'b0;
    fetch_a(8'h00, 32'hf8000001, 1'b0); tick();
    fetch_a(8'h01, 32'hf8008002, 1'b0); tick();
    idle_all(); tick();
    chk("a_idle_hold_q", q_a, 32'hf8008002);
    chk("a_idle_q_valid", {31'd0, q_valid_a}, 32'd0);

    load_a(8'h05, 32'haaaa0005); tick();
    load_a(8'h06, 32'hbbbb0006); tick();
    ld_en_a = 1'b0;
    fetch_a(8'h05, 32'haaaa0005, 1'b0); tick();
    for (int i = 0; i < 3; i++) begin
      stall_a = 1'b1; fetch_req_a = 1'b1; addr_a = 8'h06;
      if (i == 1) load_a(8'h07, 32'hcccc0007);
      else ld_en_a = 1'b0;
      sb_a.push_back('{cyc + 1, 32'haaaa0005, 1'b0});
      tick();
    end
    ld_en_a = 1'b0;
    fetch_a(8'h06, 32'hbbbb0006, 1'b0); tick();
    fetch_a(8'h07, 32'hcccc0007, 1'b0); tick();
    idle_all(); tick();

    load_a(8'h20, 32'hcb050083);
    fetch_a(8'h20, 32'hcb050083, 1'b0); tick();
    ld_en_a = 1'b0;
    fetch_a(8'h20, 32'hcb050083, 1'b0); tick();
    idle_all(); tick();

    fetch_b(8'hc8, FILL, 1'b1); tick();
    load_b(8'h00, 32'h11111111); fetch_req_b = 1'b0; tick();
    load_b(8'hc7, 32'h22222222); tick();
    load_b(8'hc8, 32'h33333333);
    fetch_b(8'hc8, FILL, 1'b1); tick();
    ld_en_b = 1'b0;
    fetch_b(8'h00, 32'h11111111, 1'b0); tick();
    fetch_b(8'hc7, 32'h22222222, 1'b0); tick();
    fetch_b(8'hff, FILL, 1'b1); tick();
    idle_all(); tick(); tick();

    rst_n = 1'b0; tick(); tick();
    chk("rst2_q", q_a, FILL);
    chk("rst2_ready", {31'd0, ready_a}, 32'd0);
    rst_n = 1'b1;
    for (int i = 0; i < 100; i++) tick();
    chk("mid_clear_ready", {31'd0, ready_a}, 32'd0);
    rst_n = 1'b0; tick();
    rst_n = 1'b1;
    n = 0;
    do begin
      tick(); n++;
    end while (!ready_a && n < 400);
    chk("a_reclear_cycles", n, 32'd256);
    fetch_a(8'h00, FILL, 1'b0);
    fetch_b(8'hc7, FILL, 1'b0); tick();
    fetch_a(8'h01, FILL, 1'b0);
    fetch_req_b = 1'b0; tick();
    fetch_a(8'h20, FILL, 1'b0); tick();
    idle_all(); tick(); tick();

    chk("a_sb_drained", sb_a.size(), 32'd0);
    chk("b_sb_drained", sb_b.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
